change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Downstream stage of the vending controller. It accepts a change amount over a valid/ready handshake and pays it out one coin at a time to the coin-ejector mechanism. Payout is greedy, largest denomination first, over the 50/20/10/5 denominations. The block keeps a per-denomination coin inventory, supports refill, and reports any amount it could not pay.

Parameters:
AMT_W, 8, width of the change amount and residual, in cents
CNT_W, 6, width of each inventory counter (saturating)
INIT_CNT, 4, inventory loaded into every denomination at reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
chg_valid  in  1  change request valid
chg_amount  in  AMT_W  change to pay, in cents
chg_ready  out  1  block idle and can accept a request
coin_out_valid  out  1  coin eject request
coin_out_sel  out  2  denomination: 00=5, 01=10, 10=20, 11=50
coin_out_ack  in  1  ejector has taken the coin
refill  in  1  add one coin of refill_sel to inventory
refill_sel  in  2  refill denomination, same encoding as coin_out_sel
done  out  1  one-cycle pulse when a request completes
short  out  1  valid with done; 1 = amount not fully paid
remaining  out  AMT_W  unpaid residual, valid with done, held until next done
inv_empty  out  4  per-denomination inventory==0 flag, bit index = sel encoding

Behaviour:
- Reset (async, rst low):
  - FSM goes to IDLE.
  - All inventories load INIT_CNT; internal residual register rem=0.
  - chg_ready=1, coin_out_valid=0, coin_out_sel=0, done=0, short=0, remaining=0.
  - Assertion mid-dispense aborts immediately: coin_out_valid drops asynchronously and no partial state survives.
- FSM states IDLE, SELECT, DISPENSE, DONE:
  - IDLE: chg_ready=1. When chg_valid=1, latch rem=chg_amount and go to SELECT. chg_ready=0 in every other state; chg_valid is ignored there.
  - SELECT (1 cycle): if rem==0, go to DONE. Otherwise pick the largest denomination d with value(d)<=rem and inv[d]>0. If one exists, register coin_out_sel=d and go to DISPENSE; if none exists, go to DONE.
  - DISPENSE: coin_out_valid=1 with coin_out_sel stable. Both hold until coin_out_ack=1 is sampled. On ack: rem-=value(d), inv[d]-=1, coin_out_valid deasserts next cycle, go to SELECT. Ack may arrive in the first valid cycle.
  - DONE (1 cycle): done=1, short=(rem!=0), remaining=rem, then go to IDLE.
- coin_out_ack while coin_out_valid=0 is ignored.
- Latency: request accepted at edge t gives first coin_out_valid at t+2. Each coin costs 2 cycles with immediate ack (DISPENSE + SELECT). Request with amount 0 gives done at t+2.
- Subtraction never underflows, because the SELECT guard requires value(d)<=rem.
- Amounts that are not multiples of 5 end with short=1 and remaining = the residual.
- Refill:
  - Accepted in any state; inv[refill_sel]+=1, saturating at 2^CNT_W-1.
  - Same-cycle refill and dispense-ack on the same denomination: net count unchanged.
  - A refill landing before the next SELECT is visible to that SELECT.
- inv_empty is combinational from the inventory registers.

Test Plan:
- Reset, chg_amount=85, ack every coin immediately -> coins 50,20,10,5 in order; done=1, short=0, remaining=0; inventories 3,3,3,3; inv_empty=0000.
- After reset, amount=255, then amount=40:
  - 255 -> coins 50,50,50,50,20,20,10,5, done short=0, inv_empty[3]=1.
  - 40 -> coins 20,20, done short=0.
- amount=7 -> one coin 5, then done=1, short=1, remaining=2.
- amount=0 accepted at t -> no coin_out_valid, done=1 at t+2 with short=0.
- Ack held off 3 cycles while chg_valid=1 with amount=10 -> coin_out_valid and coin_out_sel stable for 4 cycles; chg_ready=0 and the second request is not taken until after done.
- Reset pulsed during DISPENSE of a 50 -> coin_out_valid=0 at once; inventories back to 4; after release chg_ready=1 and a fresh amount=50 pays one 50.
- refill sel=11 in the same cycle as ack of a 50 with inv50=3 -> inv50 stays 3.
- refill at inv=63 -> inv stays 63.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout (50/20/10/5) over a valid/ready request,
// one coin per ejector handshake, with per-denomination saturating inventory.
module change_dispenser #(
  parameter int AMT_W    = 8,
  parameter int CNT_W    = 6,
  parameter int INIT_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amount,
  output logic             chg_ready,
  output logic             coin_out_valid,
  output logic [1:0]       coin_out_sel,
  input  logic             coin_out_ack,
  input  logic             refill,
  input  logic [1:0]       refill_sel,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [3:0]       inv_empty
);

  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] inv [4];
  logic [AMT_W-1:0] rem;
  logic             pick_ok;
  logic [1:0]       pick_sel;
  logic [3:0]       inc_v, dec_v;
  logic             ack_take;

  // Coin value in cents for a denomination code.
  function automatic logic [AMT_W-1:0] denom(input logic [1:0] s);
    case (s)
      2'd0:    denom = AMT_W'(5);
      2'd1:    denom = AMT_W'(10);
      2'd2:    denom = AMT_W'(20);
      default: denom = AMT_W'(50);
    endcase
  endfunction

  assign ack_take = (state == DISPENSE) && coin_out_ack;

  // Largest denomination that fits the residual and is in stock (codes ascend with value).
  always_comb begin
    pick_ok  = 1'b0;
    pick_sel = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (inv[i] != '0 && denom(2'(i)) <= rem) begin
        pick_ok  = 1'b1;
        pick_sel = 2'(i);
      end
    end
  end

  // State register; reset aborts any payout in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt      = state;
    chg_ready      = 1'b0;
    coin_out_valid = 1'b0;
    done           = 1'b0;
    unique case (state)
      IDLE: begin
        chg_ready = 1'b1;
        if (chg_valid) state_nxt = SELECT;
      end
      SELECT: begin
        if (rem != '0 && pick_ok) state_nxt = DISPENSE;
        else                      state_nxt = DONE;
      end
      DISPENSE: begin
        coin_out_valid = 1'b1;
        if (coin_out_ack) state_nxt = SELECT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Residual, selected coin and completion status.
  // short/remaining are loaded on entry to DONE so they are valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem          <= '0;
      coin_out_sel <= 2'd0;
      short        <= 1'b0;
      remaining    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (chg_valid) rem <= chg_amount;
        end
        SELECT: begin
          if (rem != '0 && pick_ok) begin
            coin_out_sel <= pick_sel;
          end else begin
            short     <= (rem != '0);
            remaining <= rem;
          end
        end
        DISPENSE: begin
          if (coin_out_ack) rem <= rem - denom(coin_out_sel);
        end
        default: ;
      endcase
    end
  end

  // Per-denomination refill and payout strobes.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      inc_v[i] = refill && (refill_sel == 2'(i));
      dec_v[i] = ack_take && (coin_out_sel == 2'(i));
    end
  end

  // Inventory counters: refill saturates, a same-cycle refill and payout cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) inv[i] <= CNT_W'(INIT_CNT);
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (inc_v[i] && !dec_v[i]) begin
          if (inv[i] != '1) inv[i] <= inv[i] + CNT_W'(1);
        end else if (dec_v[i] && !inc_v[i]) begin
          inv[i] <= inv[i] - CNT_W'(1);
        end
      end
    end
  end

  // Empty flags straight from the counters.
  always_comb begin
    inv_empty = '0;
    for (int unsigned i = 0; i < 4; i++) inv_empty[i] = (inv[i] == '0);
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed vector table, corner sequences and
// randomized requests checked against a greedy inventory model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       chg_valid = 1'b0;
  logic [7:0] chg_amount = '0;
  logic       chg_ready;
  logic       coin_out_valid;
  logic [1:0] coin_out_sel;
  logic       coin_out_ack = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_sel = '0;
  logic       done;
  logic       short;
  logic [7:0] remaining;
  logic [3:0] inv_empty;

  change_dispenser #(.AMT_W(8), .CNT_W(6), .INIT_CNT(4)) dut (
    .clk(clk), .rst(rst),
    .chg_valid(chg_valid), .chg_amount(chg_amount), .chg_ready(chg_ready),
    .coin_out_valid(coin_out_valid), .coin_out_sel(coin_out_sel), .coin_out_ack(coin_out_ack),
    .refill(refill), .refill_sel(refill_sel),
    .done(done), .short(short), .remaining(remaining), .inv_empty(inv_empty)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference inventory.
  int unsigned m_inv [4];

  // Result of the most recent request.
  int unsigned got_n;
  logic [1:0]  got_sels [64];
  int unsigned got_short;
  int unsigned got_rem;

  typedef struct {
    bit          rst_first;
    int unsigned amount;
    int unsigned ncoins;
    logic [15:0] sels;     // coin k code in bits [2k+1:2k]
    bit          exp_short;
    int unsigned exp_rem;
    logic [3:0]  exp_ie;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned val(input int unsigned s);
    case (s)
      0: return 5;
      1: return 10;
      2: return 20;
      default: return 50;
    endcase
  endfunction

  function automatic bit model_pick(input int unsigned r, output logic [1:0] s);
    for (int i = 3; i >= 0; i--) begin
      if (m_inv[i] > 0 && val(i) <= r) begin
        s = 2'(i);
        return 1'b1;
      end
    end
    s = 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (m_inv[i] == 0);
    return e;
  endfunction

  function automatic void model_refill(input int unsigned s);
    if (m_inv[s] < 63) m_inv[s]++;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    coin_out_ack = 1'b0;
    refill = 1'b0;
    chg_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_inv[i] = 4;
    @(posedge clk); #1;
    chk("rst_chg_ready", chg_ready, 1);
    chk("rst_coin_valid", coin_out_valid, 0);
    chk("rst_coin_sel", coin_out_sel, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_inv_empty", inv_empty, 0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // One request: ack_dly<0 means random ack delay 0..3 per coin.
  task automatic run_req(input int unsigned amt, input int ack_dly, input bit rnd_refill,
                         input bit ack_refill, input bit keep_valid);
    int unsigned r, c, next_evt, held, bound;
    logic [1:0] exp_sel, cur_sel;
    bit in_coin, fin, found;
    int dly;
    bound = 0;
    while (!chg_ready && bound < 20) begin
      @(posedge clk); #1;
      bound++;
    end
    chk("ready_before_req", chg_ready, 1);
    chg_valid = 1'b1;
    chg_amount = 8'(amt);
    @(posedge clk); #1;
    if (!keep_valid) chg_valid = 1'b0;
    r = amt; c = 0; next_evt = 1; in_coin = 0; fin = 0; got_n = 0;
    held = 0; dly = 0; cur_sel = 2'd0; exp_sel = 2'd0; found = 0;
    while (!fin && c < 2000) begin
      coin_out_ack = 1'b0;
      refill = 1'b0;
      chk("busy_not_ready", chg_ready, 0);
      if (done) begin
        chk("done_latency", c, next_evt);
        chk("coin_valid_at_done", coin_out_valid, 0);
        chk("short", short, (r != 0));
        chk("remaining", remaining, r);
        chk("inv_empty", inv_empty, model_empty());
        found = model_pick(r, exp_sel);
        chk("done_while_payable", found, 0);
        got_short = short;
        got_rem = remaining;
        fin = 1;
      end else if (coin_out_valid) begin
        if (!in_coin) begin
          chk("coin_latency", c, next_evt);
          found = model_pick(r, exp_sel);
          chk("coin_sel", coin_out_sel, found ? exp_sel : 4);
          cur_sel = coin_out_sel;
          if (got_n < 64) got_sels[got_n] = coin_out_sel;
          got_n++;
          in_coin = 1;
          held = 0;
          dly = (ack_dly < 0) ? int'($urandom_range(3, 0)) : ack_dly;
        end else begin
          chk("sel_stable", coin_out_sel, cur_sel);
        end
        if (held == dly) begin
          coin_out_ack = 1'b1;
          if (found) begin
            r -= val(exp_sel);
            m_inv[exp_sel]--;
          end
          if (ack_refill) begin
            refill = 1'b1;
            refill_sel = cur_sel;
          end
          in_coin = 0;
          next_evt = c + 2;
        end else begin
          held++;
        end
        if (rnd_refill && !refill && $urandom_range(3, 0) == 0) begin
          refill = 1'b1;
          refill_sel = 2'($urandom_range(3, 0));
        end
        if (refill) model_refill(refill_sel);
      end else if (in_coin) begin
        chk("valid_held", coin_out_valid, 1);
      end
      if (!fin) begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk("request_completed", fin, 1);
    coin_out_ack = 1'b0;
    refill = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse_1cyc", done, 0);
    chk("idle_ready", chg_ready, 1);
  endtask

  task automatic idle_refills(input int unsigned n, input bit rnd, input logic [1:0] s);
    for (int unsigned k = 0; k < n; k++) begin
      refill = 1'b1;
      refill_sel = rnd ? 2'($urandom_range(3, 0)) : s;
      model_refill(refill_sel);
      @(posedge clk); #1;
    end
    refill = 1'b0;
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b1, 85,  4, 16'h001B, 1'b0, 0,  4'b0000};
    tbl[1] = '{1'b1, 255, 8, 16'h1AFF, 1'b0, 0,  4'b1000};
    tbl[2] = '{1'b0, 40,  2, 16'h000A, 1'b0, 0,  4'b1100};
    tbl[3] = '{1'b0, 7,   1, 16'h0000, 1'b1, 2,  4'b1100};
    tbl[4] = '{1'b0, 0,   0, 16'h0000, 1'b0, 0,  4'b1100};
    tbl[5] = '{1'b0, 85,  5, 16'h0015, 1'b1, 45, 4'b1111};
    tbl[6] = '{1'b0, 30,  0, 16'h0000, 1'b1, 30, 4'b1111};

    #1;
    for (int i = 0; i < 7; i++) begin
      logic [15:0] sv;
      if (tbl[i].rst_first) do_reset();
      run_req(tbl[i].amount, 0, 1'b0, 1'b0, 1'b0);
      sv = tbl[i].sels;
      chk("tbl_ncoins", got_n, tbl[i].ncoins);
      for (int unsigned k = 0; k < tbl[i].ncoins && k < got_n; k++)
        chk("tbl_coin", got_sels[k], sv[2*k +: 2]);
      chk("tbl_short", got_short, tbl[i].exp_short);
      chk("tbl_remaining", got_rem, tbl[i].exp_rem);
      chk("tbl_inv_empty", inv_empty, tbl[i].exp_ie);
    end

    // Ack held off 3 cycles while a second request waits on chg_valid.
    do_reset();
    run_req(10, 3, 1'b0, 1'b0, 1'b1);
    chk("hold_ncoins", got_n, 1);
    chk("hold_coin", got_sels[0], 1);
    run_req(10, 0, 1'b0, 1'b0, 1'b0);
    chk("second_req_coin", got_sels[0], 1);

    // Reset asserted mid-dispense of a 50.
    do_reset();
    chg_valid = 1'b1;
    chg_amount = 8'd50;
    @(posedge clk); #1;
    chg_valid = 1'b0;
    for (int k = 0; k < 10 && !coin_out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_valid", coin_out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_valid_async", coin_out_valid, 0);
    chk("abort_ready", chg_ready, 1);
    for (int i = 0; i < 4; i++) m_inv[i] = 4;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_req(50, 0, 1'b0, 1'b0, 1'b0);
    chk("post_abort_ncoins", got_n, 1);
    chk("post_abort_coin", got_sels[0], 3);
    run_req(150, 0, 1'b0, 1'b0, 1'b0);
    chk("post_abort_inv50", inv_empty[3], 1);

    // Refill of 50 in the ack cycle of a 50 with three in stock.
    do_reset();
    run_req(50, 0, 1'b0, 1'b0, 1'b0);
    run_req(50, 0, 1'b0, 1'b1, 1'b0);
    run_req(200, 0, 1'b0, 1'b0, 1'b0);
    chk("refill_ack_ncoins", got_n, 6);
    chk("refill_ack_coin3", got_sels[3], 2);

    // Saturation: 60 refills from 4 would wrap a 6-bit counter to 0.
    do_reset();
    idle_refills(60, 1'b0, 2'd0);
    chk("sat_not_empty", inv_empty[0], 0);
    run_req(255, -1, 1'b0, 1'b0, 1'b0);

    // Randomized requests with random ack delays and refills.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      idle_refills($urandom_range(3, 0), 1'b1, 2'd0);
      run_req($urandom_range(255, 0), -1, 1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
